acca_mul_seq: RTL and testbench

//  Multi-cycle sequencer for the ACCA 8x8 approximate multiplier family: time-shares ONE 4x4
//  sub-multiplier across the four nibble partial products (HH, HL, LH, LL) and accumulates them.

---
 rtl/acca_pkg.sv | 69 ++++++
 rtl/acca_mul_seq_if.sv | 23 ++
 rtl/acca_pp_unit.sv | 17 +
 rtl/ap1.sv | 10 +
 rtl/ap4.sv | 14 +
 rtl/acca_mul_seq.sv | 109 ++++++++++
 tb/tb_acca_mul_seq.sv | 260 ++++++++++++++++++++++++++
 7 files changed

// File: rtl/acca_pkg.sv
// Shared types and helpers for the ACCA sequential 8x8 multiplier: FSM states,
// partial-product select codes, shift amounts and mask bit positions.
package acca_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HH,
        ST_HL,
        ST_LH,
        ST_LL,
        ST_DONE
    } state_e;

    // Bit positions inside EXACT_MASK; the select codes reuse them so a code indexes the mask.
    localparam int MB_LL = 0;
    localparam int MB_LH = 1;
    localparam int MB_HL = 2;
    localparam int MB_HH = 3;

    typedef enum logic [1:0] {
        PP_LL = 2'(MB_LL),
        PP_LH = 2'(MB_LH),
        PP_HL = 2'(MB_HL),
        PP_HH = 2'(MB_HH)
    } pp_sel_e;

    localparam logic [3:0] SH_HH  = 4'd8;
    localparam logic [3:0] SH_MID = 4'd4;
    localparam logic [3:0] SH_LL  = 4'd0;

    function automatic logic [3:0] pp_shift(pp_sel_e sel);
        case (sel)
            PP_HH:   return SH_HH;
            PP_LL:   return SH_LL;
            default: return SH_MID;
        endcase
    endfunction

    function automatic state_e sel_state(pp_sel_e sel);
        case (sel)
            PP_HH:   return ST_HH;
            PP_HL:   return ST_HL;
            PP_LH:   return ST_LH;
            default: return ST_LL;
        endcase
    endfunction

    // One bit per partial product (indexed by select code): 1 = it must be computed.
    function automatic logic [3:0] active_pps(logic [7:0] a, logic [7:0] b, bit skip_zero);
        logic [3:0] act;
        act[MB_HH] = (a[7:4] != 4'd0) && (b[7:4] != 4'd0);
        act[MB_HL] = (a[7:4] != 4'd0) && (b[3:0] != 4'd0);
        act[MB_LH] = (a[3:0] != 4'd0) && (b[7:4] != 4'd0);
        act[MB_LL] = (a[3:0] != 4'd0) && (b[3:0] != 4'd0);
        return skip_zero ? act : 4'hF;
    endfunction

    // Sequence order is HH, HL, LH, LL, i.e. descending select code; pick the first
    // active product whose code is below `below`, or DONE when none is left.
    function automatic state_e first_active(logic [3:0] act, logic [2:0] below);
        state_e nxt;
        nxt = ST_DONE;
        for (int i = 0; i < 4; i++) begin
            if ((i < int'(below)) && act[i]) nxt = sel_state(pp_sel_e'(2'(i)));
        end
        return nxt;
    endfunction

endpackage

// File: rtl/acca_mul_seq_if.sv
// Operand/result stream bundle for acca_mul_seq: valid/ready in, valid/ready out, busy flag.
interface acca_mul_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prod;
    logic        busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_prod, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_prod, busy
    );

endinterface

// File: rtl/acca_pp_unit.sv
// Shared 4x4 partial-product unit: exact (ap1) or approximate (ap4) result chosen per call.
module acca_pp_unit (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       exact_i,
    output logic [7:0] pp_o
);

    logic [7:0] p_exact;
    logic [7:0] p_approx;

    ap1 u_ap1 (.a_i(x_i), .b_i(y_i), .p_o(p_exact));
    ap4 u_ap4 (.a_i(x_i), .b_i(y_i), .p_o(p_approx));

    assign pp_o = exact_i ? p_exact : p_approx;

endmodule

// File: rtl/ap1.sv
// ACCA ap1 4x4 multiplier: exact 8-bit product.
module ap1 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    assign p_o = {4'b0, a_i} * {4'b0, b_i};

endmodule

// File: rtl/ap4.sv
// ACCA ap4 4x4 multiplier: exact product with the two LSBs forced high (never underestimates);
// a zero operand still yields zero.
module ap4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    logic [7:0] exact;

    assign exact = {4'b0, a_i} * {4'b0, b_i};
    assign p_o   = (exact == 8'd0) ? 8'd0 : (exact | 8'h03);

endmodule

// File: rtl/acca_mul_seq.sv
// Sequential ACCA 8x8 multiplier: one shared 4x4 unit walks HH, HL, LH, LL and accumulates
// the shifted partial products; valid/ready stream on both sides.
module acca_mul_seq
    import acca_pkg::*;
#(
    parameter logic [3:0] EXACT_MASK = 4'b1000,
    parameter bit         SKIP_ZERO  = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    acca_mul_seq_if.slave bus
);

    state_e      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] prod_q, prod_d;

    logic        in_ready;
    logic        load;
    logic [3:0]  act_in;
    logic [3:0]  act_reg;
    pp_sel_e     pp_sel;
    logic [3:0]  pp_x;
    logic [3:0]  pp_y;
    logic [7:0]  pp;

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign act_in   = active_pps(bus.in_a, bus.in_b, SKIP_ZERO);
    assign act_reg  = active_pps(a_q, b_q, SKIP_ZERO);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pp_sel = PP_LL;
        pp_x   = a_q[3:0];
        pp_y   = b_q[3:0];
        case (state_q)
            ST_HH: begin pp_sel = PP_HH; pp_x = a_q[7:4]; pp_y = b_q[7:4]; end
            ST_HL: begin pp_sel = PP_HL; pp_x = a_q[7:4]; pp_y = b_q[3:0]; end
            ST_LH: begin pp_sel = PP_LH; pp_x = a_q[3:0]; pp_y = b_q[7:4]; end
            default: ;
        endcase
    end

    acca_pp_unit u_pp (
        .x_i     (pp_x),
        .y_i     (pp_y),
        .exact_i (EXACT_MASK[pp_sel]),
        .pp_o    (pp)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        load    = 1'b0;

        case (state_q)
            ST_IDLE: load = bus.in_valid;
            ST_HH, ST_HL, ST_LH, ST_LL: begin
                acc_d   = acc_q + (16'(pp) << pp_shift(pp_sel));
                state_d = first_active(act_reg, {1'b0, pp_sel});
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    load = bus.in_valid;
                    if (!bus.in_valid) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            a_d     = bus.in_a;
            b_d     = bus.in_b;
            acc_d   = 16'd0;
            state_d = first_active(act_in, 3'd4);
        end

        // Latch the result on every entry into DONE, including an all-skipped accept from DONE.
        prod_d = prod_q;
        if ((state_d == ST_DONE) && ((state_q != ST_DONE) || load)) prod_d = acc_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            acc_q   <= 16'd0;
            prod_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_prod  = prod_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_acca_mul_seq.sv
// Bench for acca_mul_seq: three configurations (exact/no-skip, exact/skip, default) driven
// with directed and random operands and compared to an arithmetic reference model.
module tb_acca_mul_seq;

    localparam int NDUT = 3;
    localparam logic [3:0] CFG_MASK [NDUT] = '{4'b1111, 4'b1111, 4'b1000};
    localparam bit         CFG_SKIP [NDUT] = '{1'b0, 1'b1, 1'b1};

    logic clk;
    logic rst_n;

    logic        in_valid_s  [NDUT];
    logic [7:0]  in_a_s      [NDUT];
    logic [7:0]  in_b_s      [NDUT];
    logic        out_ready_s [NDUT];
    logic        in_ready_s  [NDUT];
    logic        out_valid_s [NDUT];
    logic [15:0] out_prod_s  [NDUT];
    logic        busy_s      [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    acca_mul_seq_if bus [NDUT] ();

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        assign bus[g].in_valid  = in_valid_s[g];
        assign bus[g].in_a      = in_a_s[g];
        assign bus[g].in_b      = in_b_s[g];
        assign bus[g].out_ready = out_ready_s[g];
        assign in_ready_s[g]    = bus[g].in_ready;
        assign out_valid_s[g]   = bus[g].out_valid;
        assign out_prod_s[g]    = bus[g].out_prod;
        assign busy_s[g]        = bus[g].busy;

        acca_mul_seq #(.EXACT_MASK(CFG_MASK[g]), .SKIP_ZERO(CFG_SKIP[g])) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: sum the four nibble products by definition, ap4 = exact | 3 when nonzero.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] mask,
                         input bit skip, output logic [15:0] p, output int n);
        int          xs  [4];
        int          ys  [4];
        int          shs [4];
        int          mbs [4];
        int unsigned sum;
        xs  = '{int'(a[7:4]), int'(a[7:4]), int'(a[3:0]), int'(a[3:0])};
        ys  = '{int'(b[7:4]), int'(b[3:0]), int'(b[7:4]), int'(b[3:0])};
        shs = '{8, 4, 4, 0};
        mbs = '{3, 2, 1, 0};
        sum = 0;
        n   = 0;
        for (int k = 0; k < 4; k++) begin
            int v;
            if (skip && (xs[k] == 0 || ys[k] == 0)) continue;
            n++;
            v = xs[k] * ys[k];
            if (!mask[mbs[k]] && v != 0) v = v | 3;
            sum += int'(unsigned'(v) << shs[k]);
        end
        p = 16'(sum);
    endtask

    function automatic logic [3:0] rnib();
        return ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    endfunction

    // Called at a negedge with operands presented; returns right after the accept edge.
    task automatic wait_accept(input int s, input string tag);
        int g = 0;
        while (!in_ready_s[s] && g < 20) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_accept"}, 32'(in_ready_s[s]), 32'd1);
        @(posedge clk);
    endtask

    // Called at the first negedge after the accept edge k. Latency counts the edge at which
    // the consumer first sees out_valid, so an operation with N computed products gives N+1.
    task automatic wait_result(input int s, input string tag, input logic [15:0] exp_p,
                               input int exp_lat);
        int lat = 1;
        while (!out_valid_s[s] && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_prod"}, 32'(out_prod_s[s]), 32'(exp_p));
    endtask

    task automatic run_op(input int s, input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_p, input int exp_lat, input int hold);
        @(negedge clk);
        in_valid_s[s] = 1'b1;
        in_a_s[s]     = a;
        in_b_s[s]     = b;
        wait_accept(s, tag);
        @(negedge clk);
        in_valid_s[s] = 1'b0;
        in_a_s[s]     = 8'($urandom);
        in_b_s[s]     = 8'($urandom);
        wait_result(s, tag, exp_p, exp_lat);
        repeat (hold) begin
            @(negedge clk);
            check({tag, "_hold"}, 32'(out_prod_s[s]), 32'(exp_p));
        end
        out_ready_s[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_s[s] = 1'b0;
        check({tag, "_idle"}, {30'd0, out_valid_s[s], busy_s[s]}, 32'd0);
    endtask

    task automatic run_rand(input int s);
        logic [7:0]  a, b;
        logic [15:0] p;
        int          n;
        a = {rnib(), rnib()};
        b = {rnib(), rnib()};
        model(a, b, CFG_MASK[s], CFG_SKIP[s], p, n);
        run_op(s, $sformatf("rand%0d_%02h_%02h", s, a, b), a, b, p, n + 1, $urandom_range(0, 2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] p1, p2;
        int          n1, n2, seen;

        rst_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            in_valid_s[i]  = 1'b0;
            in_a_s[i]      = 8'h00;
            in_b_s[i]      = 8'h00;
            out_ready_s[i] = 1'b0;
        end
        #12;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst%0d_in_ready", i), 32'(in_ready_s[i]), 32'd1);
            check($sformatf("rst%0d_out_valid", i), 32'(out_valid_s[i]), 32'd0);
            check($sformatf("rst%0d_busy", i), 32'(busy_s[i]), 32'd0);
            check($sformatf("rst%0d_prod", i), 32'(out_prod_s[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the datasheet.
        run_op(0, "ff_x_ff", 8'hFF, 8'hFF, 16'hFE01, 5, 1);
        run_op(1, "zero_a", 8'h00, 8'h5A, 16'h0000, 1, 0);
        run_op(1, "only_hl", 8'h30, 8'h07, 16'h0150, 2, 0);

        // Back-to-back with in_valid held and out_ready high: no IDLE bubble.
        @(negedge clk);
        in_valid_s[1]  = 1'b1;
        in_a_s[1]      = 8'd12;
        in_b_s[1]      = 8'd13;
        out_ready_s[1] = 1'b1;
        wait_accept(1, "b2b_1");
        @(negedge clk);
        in_a_s[1] = 8'd200;
        in_b_s[1] = 8'd3;
        wait_result(1, "b2b_1", 16'd156, 2);
        check("b2b_in_ready_in_done", 32'(in_ready_s[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid_s[1] = 1'b0;
        check("b2b_no_bubble_busy", 32'(busy_s[1]), 32'd1);
        check("b2b_no_bubble_valid", 32'(out_valid_s[1]), 32'd0);
        wait_result(1, "b2b_2", 16'd600, 3);
        @(posedge clk);
        @(negedge clk);
        out_ready_s[1] = 1'b0;
        check("b2b_back_idle", 32'(busy_s[1]), 32'd0);

        // Backpressure: result held for 10 cycles, pending operands refused until consumed.
        model(8'h9C, 8'h57, CFG_MASK[2], CFG_SKIP[2], p1, n1);
        model(8'h21, 8'h43, CFG_MASK[2], CFG_SKIP[2], p2, n2);
        @(negedge clk);
        in_valid_s[2] = 1'b1;
        in_a_s[2]     = 8'h9C;
        in_b_s[2]     = 8'h57;
        wait_accept(2, "bp_1");
        @(negedge clk);
        in_valid_s[2] = 1'b0;
        wait_result(2, "bp_1", p1, n1 + 1);
        in_valid_s[2] = 1'b1;
        in_a_s[2]     = 8'h21;
        in_b_s[2]     = 8'h43;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp_stable_c%0d", c), 32'(out_prod_s[2]), 32'(p1));
            check($sformatf("bp_in_ready_c%0d", c), {30'd0, in_ready_s[2], out_valid_s[2]}, 32'd1);
        end
        out_ready_s[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_s[2]  = 1'b0;
        out_ready_s[2] = 1'b0;
        wait_result(2, "bp_2", p2, n2 + 1);
        out_ready_s[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_s[2] = 1'b0;

        // Random operands on every configuration, the default one most heavily.
        for (int i = 0; i < 1000; i++) run_rand(2);
        for (int i = 0; i < 60; i++) run_rand(0);
        for (int i = 0; i < 60; i++) run_rand(1);

        // Reset pulse while the default DUT sits in LH: abort without a result.
        @(negedge clk);
        in_valid_s[2] = 1'b1;
        in_a_s[2]     = 8'h9B;
        in_b_s[2]     = 8'hC7;
        wait_accept(2, "abort");
        @(negedge clk);
        in_valid_s[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready_s[2]), 32'd1);
        check("abort_out_valid", 32'(out_valid_s[2]), 32'd0);
        check("abort_busy", 32'(busy_s[2]), 32'd0);
        check("abort_prod", 32'(out_prod_s[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid_s[2]) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_rand(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
